// File: rtl/sddt_c2h_packer.sv
// Card-to-host read-data packetizer: buffers DDR4 read beats and frames fixed-length AXI-Stream packets.
// Optional statistics (packet counter, saturating drop counter) enabled by defining SDDT_C2H_STATS_EN.
module sddt_c2h_packer #(
  parameter int DATA_WIDTH = 512,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                          c0_ddr4_clk,
  input  logic                          c0_ddr4_rst,
  input  logic                          rd_data_valid,
  input  logic [DATA_WIDTH-1:0]         rd_data,
  input  logic [LEN_WIDTH-1:0]          pkt_len,
  input  logic                          flush,
  output logic [DATA_WIDTH-1:0]         M_AXIS_C2H_tdata,
  output logic                          M_AXIS_C2H_tvalid,
  output logic [DATA_WIDTH/8-1:0]       M_AXIS_C2H_tkeep,
  output logic                          M_AXIS_C2H_tlast,
  input  logic                          M_AXIS_C2H_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [15:0]                   pkt_count
);

  localparam int BUF_DEPTH = FIFO_DEPTH - 1;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);

  function automatic logic [LEN_WIDTH-1:0] len_norm(input logic [LEN_WIDTH-1:0] len);
    return (len == '0) ? LEN_WIDTH'(1) : len;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]      buf_cnt_q, cnt_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q, tlast_q;
  logic [LEN_WIDTH-1:0]  load_idx_q, len_q;
  logic                  flush_pend_q;

  logic                  pop, push_acc, drop, buf_empty, load, buf_wr, buf_rd;
  logic                  flush_eff, load_last, pkt_open;
  logic [LEN_WIDTH-1:0]  len_eff;
  logic [DATA_WIDTH-1:0] load_data;

  // Load/push decision: output slot refills from buffer head, or bypasses rd_data when the buffer is empty
  always_comb begin
    pop       = tvalid_q & M_AXIS_C2H_tready;
    push_acc  = rd_data_valid & ((cnt_q < FULL_CNT) | pop);
    drop      = rd_data_valid & ~push_acc;
    buf_empty = (buf_cnt_q == '0);
    load      = (~tvalid_q | pop) & (~buf_empty | push_acc);
    buf_rd    = load & ~buf_empty;
    buf_wr    = push_acc & ~(load & buf_empty);
    load_data = buf_empty ? rd_data : buf_mem[rd_ptr_q];
    pkt_open  = (load_idx_q != '0);
    flush_eff = flush & pkt_open;
    len_eff   = pkt_open ? len_q : len_norm(pkt_len);
    load_last = (load_idx_q == len_eff - LEN_WIDTH'(1)) | flush_pend_q | flush_eff;
  end

  always_ff @(posedge c0_ddr4_clk) begin
    if (buf_wr) buf_mem[wr_ptr_q] <= rd_data;
  end

  always_ff @(posedge c0_ddr4_clk) begin
    if (c0_ddr4_rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      buf_cnt_q <= '0;
      cnt_q     <= '0;
    end else begin
      if (buf_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (buf_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({buf_wr, buf_rd})
        2'b10:   buf_cnt_q <= buf_cnt_q + CNT_W'(1);
        2'b01:   buf_cnt_q <= buf_cnt_q - CNT_W'(1);
        default: buf_cnt_q <= buf_cnt_q;
      endcase
      case ({push_acc, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Output register stage and packet framing state
  always_ff @(posedge c0_ddr4_clk) begin
    if (c0_ddr4_rst) begin
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      load_idx_q   <= '0;
      len_q        <= LEN_WIDTH'(1);
      flush_pend_q <= 1'b0;
    end else begin
      if (load) begin
        tdata_q  <= load_data;
        tlast_q  <= load_last;
        tvalid_q <= 1'b1;
        if (!pkt_open) len_q <= len_norm(pkt_len);
        load_idx_q <= load_last ? '0 : load_idx_q + LEN_WIDTH'(1);
      end else if (pop) begin
        tvalid_q <= 1'b0;
      end
      if (load && load_last)     flush_pend_q <= 1'b0;
      else if (flush_eff && !load) flush_pend_q <= 1'b1;
    end
  end

`ifdef SDDT_C2H_STATS_EN
  logic [15:0] pkt_count_q;
  logic [31:0] drop_cnt_q;

  always_ff @(posedge c0_ddr4_clk) begin
    if (c0_ddr4_rst) begin
      pkt_count_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (pop && tlast_q) pkt_count_q <= pkt_count_q + 16'd1;
      if (drop)           drop_cnt_q  <= sat_inc32(drop_cnt_q);
    end
  end

  assign pkt_count = pkt_count_q;
  assign overflow  = (drop_cnt_q != '0);
`else
  logic overflow_q;

  always_ff @(posedge c0_ddr4_clk) begin
    if (c0_ddr4_rst)  overflow_q <= 1'b0;
    else if (drop)    overflow_q <= 1'b1;
  end

  assign pkt_count = '0;
  assign overflow  = overflow_q;
`endif

  assign M_AXIS_C2H_tdata  = tdata_q;
  assign M_AXIS_C2H_tvalid = tvalid_q;
  assign M_AXIS_C2H_tlast  = tlast_q;
  assign M_AXIS_C2H_tkeep  = '1;
  assign fifo_count        = cnt_q;

endmodule

// File: tb/tb_sddt_c2h_packer.sv
// Scoreboard bench for sddt_c2h_packer: directed pushes queue expected {data,last}; a monitor checks every pop.
module tb_sddt_c2h_packer;
  localparam int DW = 512;
  localparam int FD = 16;
  localparam int LW = 16;
`ifdef SDDT_C2H_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_data_valid = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic [LW-1:0] pkt_len = '0;
  logic          flush = 1'b0;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast;
  logic [DW/8-1:0] tkeep;
  logic          tready = 1'b0;
  logic [4:0]    fifo_count;
  logic          overflow;
  logic [15:0]   pkt_count;

  sddt_c2h_packer #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .LEN_WIDTH(LW)) dut (
    .c0_ddr4_clk(clk), .c0_ddr4_rst(rst),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .pkt_len(pkt_len), .flush(flush),
    .M_AXIS_C2H_tdata(tdata), .M_AXIS_C2H_tvalid(tvalid), .M_AXIS_C2H_tkeep(tkeep),
    .M_AXIS_C2H_tlast(tlast), .M_AXIS_C2H_tready(tready),
    .fifo_count(fifo_count), .overflow(overflow), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] d; logic l; } exp_t;
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] held_d;
  logic          held_l;

  function automatic logic [DW-1:0] beat(input int tag);
    logic [31:0] w;
    w = 32'hA500_0000 ^ tag;
    return {16{w}};
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: compares each pop against the scoreboard and checks AXIS stability during stalls
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      n_vec++;
      if (fifo_count > 5'd16) begin
        n_err++;
        $display("FAIL fifo_count_bound: got %0d expected <= 16", fifo_count);
      end
      if (stall_prev) begin
        n_vec++;
        if (!tvalid || tdata !== held_d || tlast !== held_l) begin
          n_err++;
          $display("FAIL stall_hold: tvalid=%0b tlast=%0b data[31:0]=%h expected held tlast=%0b data[31:0]=%h",
                   tvalid, tlast, tdata[31:0], held_l, held_d[31:0]);
        end
      end
      if (tvalid && tready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: data[31:0]=%h tlast=%0b with empty scoreboard", tdata[31:0], tlast);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (tdata !== e.d || tlast !== e.l || tkeep !== '1) begin
            n_err++;
            $display("FAIL beat: data[31:0]=%h tlast=%0b tkeep_ok=%0b expected data[31:0]=%h tlast=%0b",
                     tdata[31:0], tlast, (tkeep === '1), e.d[31:0], e.l);
          end
        end
      end
      stall_prev = tvalid && !tready;
      held_d     = tdata;
      held_l     = tlast;
    end
  end

  task automatic push(input int tag, input logic last_exp, input bit kept);
    exp_t e;
    rd_data_valid = 1'b1;
    rd_data       = beat(tag);
    if (kept) begin
      e.d = beat(tag);
      e.l = last_exp;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    rd_data_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; rd_data_valid = 1'b0; flush = 1'b0; tready = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata_zero", (tdata == '0), 1);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_pkt_count", pkt_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string name, input int pk_exp);
    int n;
    n = 0;
    tready = 1'b1;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) chk({name, "_drain_timeout"}, exp_q.size(), 0);
    @(posedge clk); #1;
    chk({name, "_pkt_count"}, pkt_count, STATS ? pk_exp : 0);
    chk({name, "_fifo_empty"}, fifo_count, 0);
    chk({name, "_tvalid_idle"}, tvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] last4;
    #1;
    do_reset();

    // 8 beats, pkt_len=4, tready high
    pkt_len = 16'd4; tready = 1'b1;
    push(100, 1'b0, 1'b1);
    chk("latency_tvalid", tvalid, 1);
    push(101, 1'b0, 1'b1); push(102, 1'b0, 1'b1); push(103, 1'b1, 1'b1);
    push(104, 1'b0, 1'b1); push(105, 1'b0, 1'b1); push(106, 1'b0, 1'b1); push(107, 1'b1, 1'b1);
    drain("len4", 2);

    // flush closes a packet early while the second beat is still buffered
    do_reset();
    pkt_len = 16'd3; tready = 1'b0;
    push(200, 1'b0, 1'b1);
    push(201, 1'b1, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    push(202, 1'b0, 1'b1);
    drain("flush", 1);

    // overflow: 17 pushes with no drain, 16 survive
    do_reset();
    pkt_len = 16'd4; tready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      last4 = 4'(i);
      push(300 + i, (last4[1:0] == 2'd3), (i < 16));
    end
    @(negedge clk);
    chk("full_fifo_count", fifo_count, 16);
    chk("full_overflow", overflow, 1);
    @(posedge clk); #1;
    drain("overflow", 4);

    // tready toggling under continuous pushes, pkt_len=2
    do_reset();
    pkt_len = 16'd2; tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tready = ~tready;
      push(400 + i, (i % 2 == 1), 1'b1);
    end
    chk("toggle_no_overflow", overflow, 0);
    drain("toggle", 10);

    // pkt_len=0 behaves as 1
    do_reset();
    pkt_len = 16'd0; tready = 1'b1;
    push(500, 1'b1, 1'b1); push(501, 1'b1, 1'b1); push(502, 1'b1, 1'b1);
    drain("len0", 3);

    // reset mid-packet with 5 beats buffered, then a fresh packet
    do_reset();
    pkt_len = 16'd8; tready = 1'b0;
    for (int i = 0; i < 5; i++) push(600 + i, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_reset_count", fifo_count, 5);
    @(posedge clk); #1;
    do_reset();
    pkt_len = 16'd2; tready = 1'b1;
    push(700, 1'b0, 1'b1); push(701, 1'b1, 1'b1);
    drain("after_reset", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
